// File: rtl/id_stage_pipelined.sv
// Decode stage with ID/EX register, register file and load-use interlock; one cycle IF->EX.
// Backpressure: id_ready drops on a full stage while EX stalls, on a load-use hazard, or on flush.
module id_stage_pipelined #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int BYPASS_EN = 1,
  parameter int HAZARD_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_pc_plus4,
  input  logic [31:0]     if_instruction,
  output logic            id_ready,
  input  logic            ex_ready,
  input  logic            flush,
  input  logic            wb_write_enable,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_write_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [XLEN-1:0] id_read_data1,
  output logic [XLEN-1:0] id_read_data2,
  output logic [XLEN-1:0] id_immediate,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_func3,
  output logic [6:0]      id_func7,
  output logic            id_illegal
);
  localparam int RW = $clog2(NUM_REGS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] func3;
  logic [6:0] func7;

  assign opcode = if_instruction[6:0];
  assign rd     = if_instruction[11:7];
  assign func3  = if_instruction[14:12];
  assign rs1    = if_instruction[19:15];
  assign rs2    = if_instruction[24:20];
  assign func7  = if_instruction[31:25];

  logic [NUM_REGS-1:0][XLEN-1:0] regs;
  logic [RW-1:0]   rs1_idx;
  logic [RW-1:0]   rs2_idx;
  logic [RW-1:0]   wr_idx;
  logic            wr_vld;
  logic            bypass1;
  logic            bypass2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;

  // Index bits above RW alias onto the implemented registers, so entry 0 is x0 everywhere.
  assign rs1_idx = rs1[RW-1:0];
  assign rs2_idx = rs2[RW-1:0];
  assign wr_idx  = wb_rd[RW-1:0];
  assign wr_vld  = wb_write_enable && (wr_idx != '0);
  assign bypass1 = (BYPASS_EN != 0) && wr_vld && (wr_idx == rs1_idx);
  assign bypass2 = (BYPASS_EN != 0) && wr_vld && (wr_idx == rs2_idx);
  assign rdata1  = (rs1_idx == '0) ? '0 : (bypass1 ? wb_write_data : regs[rs1_idx]);
  assign rdata2  = (rs2_idx == '0) ? '0 : (bypass2 ? wb_write_data : regs[rs2_idx]);

  logic uses_rs1;
  logic uses_rs2;
  logic load_use;

  assign uses_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  assign load_use = (HAZARD_EN != 0) && id_valid && (id_opcode == OPC_LOAD) && (id_rd != 5'd0) &&
                    ((uses_rs1 && (rs1 == id_rd)) || (uses_rs2 && (rs2 == id_rd)));

  assign id_ready = (!id_valid || ex_ready) && !load_use && !flush;

  logic [31:0] imm32;
  logic        illegal;

  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR:
        imm32 = {{20{if_instruction[31]}}, if_instruction[31:20]};
      OPC_STORE:
        imm32 = {{20{if_instruction[31]}}, if_instruction[31:25], if_instruction[11:7]};
      OPC_BRANCH:
        imm32 = {{19{if_instruction[31]}}, if_instruction[31], if_instruction[7],
                 if_instruction[30:25], if_instruction[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {if_instruction[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{11{if_instruction[31]}}, if_instruction[31], if_instruction[19:12],
                 if_instruction[20], if_instruction[30:21], 1'b0};
      OPC_OP, OPC_FENCE, OPC_SYSTEM:
        imm32 = '0;
      default:
        illegal = 1'b1;
    endcase
  end

  logic accept;
  logic hold;

  assign accept = if_valid && id_ready;
  assign hold   = id_valid && !ex_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (wr_vld) begin
      regs[wr_idx] <= wb_write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid      <= 1'b0;
      id_pc         <= '0;
      id_pc_plus4   <= '0;
      id_read_data1 <= '0;
      id_read_data2 <= '0;
      id_immediate  <= '0;
      id_rs1        <= '0;
      id_rs2        <= '0;
      id_rd         <= '0;
      id_opcode     <= '0;
      id_func3      <= '0;
      id_func7      <= '0;
      id_illegal    <= 1'b0;
    end else begin
      if (flush) begin
        id_valid <= 1'b0;
      end else if (accept) begin
        id_valid <= 1'b1;
      end else if (ex_ready) begin
        id_valid <= 1'b0;
      end

      if (accept) begin
        id_pc         <= if_pc;
        id_pc_plus4   <= if_pc_plus4;
        id_read_data1 <= rdata1;
        id_read_data2 <= rdata2;
        id_immediate  <= XLEN'($signed(imm32));
        id_rs1        <= rs1;
        id_rs2        <= rs2;
        id_rd         <= rd;
        id_opcode     <= opcode;
        id_func3      <= func3;
        id_func7      <= func7;
        id_illegal    <= illegal;
      end else if (hold) begin
        // A held instruction keeps tracking WB so EX never consumes a stale operand.
        if (wr_vld && (wr_idx == id_rs1[RW-1:0])) id_read_data1 <= wb_write_data;
        if (wr_vld && (wr_idx == id_rs2[RW-1:0])) id_read_data2 <= wb_write_data;
      end
    end
  end
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Drives a 32-bit/32-register and a 64-bit/16-register instance from the same stimulus
// and compares both against a cycle-level reference model of the stage.
module tb_id_stage_pipelined;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [63:0] M32      = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [63:0] if_pc_plus4;
  logic [31:0] if_instruction;
  logic        ex_ready;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  logic        a_ready, a_valid, a_ill;
  logic [31:0] a_pc, a_pc4, a_rd1, a_rd2, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [6:0]  a_op, a_f7;
  logic [2:0]  a_f3;

  logic        b_ready, b_valid, b_ill;
  logic [63:0] b_pc, b_pc4, b_rd1, b_rd2, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [6:0]  b_op, b_f7;
  logic [2:0]  b_f3;

  id_stage_pipelined #(.XLEN(32), .NUM_REGS(32), .BYPASS_EN(1), .HAZARD_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc[31:0]),
    .if_pc_plus4(if_pc_plus4[31:0]), .if_instruction(if_instruction), .id_ready(a_ready),
    .ex_ready(ex_ready), .flush(flush), .wb_write_enable(wb_we), .wb_rd(wb_rd),
    .wb_write_data(wb_data[31:0]), .id_valid(a_valid), .id_pc(a_pc), .id_pc_plus4(a_pc4),
    .id_read_data1(a_rd1), .id_read_data2(a_rd2), .id_immediate(a_imm), .id_rs1(a_rs1),
    .id_rs2(a_rs2), .id_rd(a_rd), .id_opcode(a_op), .id_func3(a_f3), .id_func7(a_f7),
    .id_illegal(a_ill)
  );

  id_stage_pipelined #(.XLEN(64), .NUM_REGS(16), .BYPASS_EN(1), .HAZARD_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_instruction(if_instruction), .id_ready(b_ready),
    .ex_ready(ex_ready), .flush(flush), .wb_write_enable(wb_we), .wb_rd(wb_rd),
    .wb_write_data(wb_data), .id_valid(b_valid), .id_pc(b_pc), .id_pc_plus4(b_pc4),
    .id_read_data1(b_rd1), .id_read_data2(b_rd2), .id_immediate(b_imm), .id_rs1(b_rs1),
    .id_rs2(b_rs2), .id_rd(b_rd), .id_opcode(b_op), .id_func3(b_f3), .id_func7(b_f7),
    .id_illegal(b_ill)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: index 0 models the 32-register instance, index 1 the 16-register one.
  logic        m_valid;
  logic [63:0] m_pc, m_pc4, m_imm;
  logic [63:0] m_rd1 [2];
  logic [63:0] m_rd2 [2];
  logic [4:0]  m_rs1, m_rs2, m_rdx;
  logic [6:0]  m_op, m_f7;
  logic [2:0]  m_f3;
  logic        m_ill;
  logic [63:0] rf [2][32];

  function automatic int nregs(input int w);
    return (w == 0) ? 32 : 16;
  endfunction

  function automatic logic [63:0] model_read(input int w, input logic [4:0] idx);
    int i;
    i = int'(idx) % nregs(w);
    if (i == 0) return 64'd0;
    if (wb_we && ((int'(wb_rd) % nregs(w)) == i)) return wb_data;
    return rf[w][i];
  endfunction

  function automatic logic [63:0] model_imm(input logic [31:0] inst);
    longint l;
    l = longint'($signed(inst));
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR: return l >>> 20;
      OP_STORE:  return ((l >>> 25) <<< 5) | longint'(inst[11:7]);
      OP_BRANCH: return ((l >>> 31) <<< 12) | (longint'(inst[7]) <<< 11) |
                        (longint'(inst[30:25]) <<< 5) | (longint'(inst[11:8]) <<< 1);
      OP_LUI, OP_AUIPC: return (l >>> 12) <<< 12;
      OP_JAL:    return ((l >>> 31) <<< 20) | (longint'(inst[19:12]) <<< 12) |
                        (longint'(inst[20]) <<< 11) | (longint'(inst[30:21]) <<< 1);
      default:   return 64'd0;
    endcase
  endfunction

  function automatic logic model_illegal(input logic [6:0] op);
    logic [6:0] legal [11];
    legal = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
              OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM};
    foreach (legal[i]) if (legal[i] == op) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {OP_OP, OP_STORE, OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11];
    int pick;
    logic [4:0] rd, rs1, rs2;
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_OP, OP_LOAD, OP_OP};
    pick = $urandom_range(0, 12);
    if (pick == 12) return $urandom;
    rd  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    rs1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    rs2 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    if (pick == 11) return {7'($urandom), rs2, rs1, 3'($urandom), rd, 7'h7F};
    return {7'($urandom), rs2, rs1, 3'($urandom), rd, ops[pick]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc = '0; m_pc4 = '0; m_imm = '0;
    m_rs1 = '0; m_rs2 = '0; m_rdx = '0; m_op = '0; m_f3 = '0; m_f7 = '0; m_ill = 1'b0;
    for (int w = 0; w < 2; w++) begin
      m_rd1[w] = '0;
      m_rd2[w] = '0;
      for (int r = 0; r < 32; r++) rf[w][r] = '0;
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] inst, input logic er, input logic fl,
                       input logic we, input logic [4:0] wrd, input logic [63:0] wd);
    if_valid       = iv;
    if_instruction = inst;
    if_pc          = {$urandom, $urandom} & ~64'h3;
    if_pc_plus4    = if_pc + 64'd4;
    ex_ready       = er;
    flush          = fl;
    wb_we          = we;
    wb_rd          = wrd;
    wb_data        = wd;
  endtask

  task automatic check_outputs();
    chk("a_valid", 64'(a_valid), 64'(m_valid));
    chk("b_valid", 64'(b_valid), 64'(m_valid));
    if (m_valid) begin
      chk("a_pc", a_pc, m_pc & M32);
      chk("a_pc4", a_pc4, m_pc4 & M32);
      chk("a_rd1", a_rd1, m_rd1[0] & M32);
      chk("a_rd2", a_rd2, m_rd2[0] & M32);
      chk("a_imm", a_imm, m_imm & M32);
      chk("a_fields", {a_rs1, a_rs2, a_rd, a_op, a_f3, a_f7, a_ill},
          {m_rs1, m_rs2, m_rdx, m_op, m_f3, m_f7, m_ill});
      chk("b_pc", b_pc, m_pc);
      chk("b_pc4", b_pc4, m_pc4);
      chk("b_rd1", b_rd1, m_rd1[1]);
      chk("b_rd2", b_rd2, m_rd2[1]);
      chk("b_imm", b_imm, m_imm);
      chk("b_fields", {b_rs1, b_rs2, b_rd, b_op, b_f3, b_f7, b_ill},
          {m_rs1, m_rs2, m_rdx, m_op, m_f3, m_f7, m_ill});
    end
  endtask

  // One clock: check id_ready against the model, advance the model, check the new outputs.
  task automatic tick();
    logic [6:0] op;
    logic [4:0] irs1, irs2;
    logic       lu, exp_ready, acc;
    int         i;
    #1;
    op   = if_instruction[6:0];
    irs1 = if_instruction[19:15];
    irs2 = if_instruction[24:20];
    lu = m_valid && (m_op == OP_LOAD) && (m_rdx != 5'd0) &&
         ((reads_rs1(op) && (irs1 == m_rdx)) || (reads_rs2(op) && (irs2 == m_rdx)));
    exp_ready = (!m_valid || ex_ready) && !lu && !flush;
    chk("a_ready", 64'(a_ready), 64'(exp_ready));
    chk("b_ready", 64'(b_ready), 64'(exp_ready));
    acc = if_valid && exp_ready;
    if (flush) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_pc = if_pc; m_pc4 = if_pc_plus4;
      m_op = op; m_rdx = if_instruction[11:7]; m_f3 = if_instruction[14:12];
      m_rs1 = irs1; m_rs2 = irs2; m_f7 = if_instruction[31:25];
      m_imm = model_imm(if_instruction);
      m_ill = model_illegal(op);
      for (int w = 0; w < 2; w++) begin
        m_rd1[w] = model_read(w, irs1);
        m_rd2[w] = model_read(w, irs2);
      end
    end else if (m_valid && ex_ready) begin
      m_valid = 1'b0;
    end else if (m_valid && wb_we) begin
      for (int w = 0; w < 2; w++) begin
        i = int'(wb_rd) % nregs(w);
        if (i != 0 && i == int'(m_rs1) % nregs(w)) m_rd1[w] = wb_data;
        if (i != 0 && i == int'(m_rs2) % nregs(w)) m_rd2[w] = wb_data;
      end
    end
    if (wb_we) begin
      for (int w = 0; w < 2; w++) begin
        i = int'(wb_rd) % nregs(w);
        if (i != 0) rf[w][i] = wb_data;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 32'd0, 1, 0, 0, 5'd0, 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_a_valid", 64'(a_valid), 64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd1);
    chk("rst_a_regs", {a_pc, a_rd1, a_imm}, 64'd0);
    chk("rst_b_pc", b_pc, 64'd0);
    chk("rst_b_imm", b_imm, 64'd0);
    rst_n = 1'b1;

    // ADDI x1,x0,5 then ADD x2,x1,x1 back to back.
    drive(1, enc_i(12'd5, 5'd0, 3'd0, 5'd1, OP_IMM), 1, 0, 0, 5'd0, 64'd0);
    tick();
    chk("b2b_valid1", 64'(a_valid), 64'd1);
    chk("b2b_imm5_a", a_imm, 64'd5);
    chk("b2b_imm5_b", b_imm, 64'd5);
    drive(1, enc_r(7'd0, 5'd1, 5'd1, 3'd0, 5'd2, OP_OP), 1, 0, 0, 5'd0, 64'd0);
    tick();
    chk("b2b_valid2", 64'(a_valid), 64'd1);
    chk("b2b_imm0", a_imm, 64'd0);

    // LW x3,0(x1) followed by a dependent ADD x4,x3,x2: one bubble.
    drive(1, enc_i(12'd0, 5'd1, 3'd2, 5'd3, OP_LOAD), 1, 0, 0, 5'd0, 64'd0);
    tick();
    drive(1, enc_r(7'd0, 5'd2, 5'd3, 3'd0, 5'd4, OP_OP), 1, 0, 0, 5'd0, 64'd0);
    #1;
    chk("lu_stall_ready", 64'(a_ready), 64'd0);
    tick();
    chk("lu_bubble", 64'(a_valid), 64'd0);
    tick();
    chk("lu_add_valid", 64'(b_valid), 64'd1);
    chk("lu_add_rd", 64'(b_rd), 64'd4);
    // Same pair with rd=x0 must not stall.
    drive(1, enc_i(12'd0, 5'd1, 3'd2, 5'd0, OP_LOAD), 1, 0, 0, 5'd0, 64'd0);
    tick();
    drive(1, enc_r(7'd0, 5'd2, 5'd0, 3'd0, 5'd4, OP_OP), 1, 0, 0, 5'd0, 64'd0);
    #1;
    chk("x0_load_ready", 64'(a_ready), 64'd1);
    tick();
    chk("x0_load_valid", 64'(a_valid), 64'd1);

    // Bypass on accept, then refresh while held.
    drive(1, enc_r(7'd0, 5'd0, 5'd7, 3'd0, 5'd8, OP_OP), 1, 0, 1, 5'd7, 64'hDEADBEEF);
    tick();
    chk("bypass_a", a_rd1, 64'hDEADBEEF);
    chk("bypass_b", b_rd1, 64'hDEADBEEF);
    drive(0, 32'd0, 0, 0, 1, 5'd7, 64'h12);
    tick();
    chk("refresh_valid", 64'(a_valid), 64'd1);
    chk("refresh_a", a_rd1, 64'h12);
    chk("refresh_b", b_rd1, 64'h12);

    // Flush with a concurrent WB write, then read the written register.
    drive(1, enc_i(12'd1, 5'd0, 3'd0, 5'd11, OP_IMM), 0, 1, 1, 5'd9, 64'h55);
    tick();
    chk("flush_valid", 64'(a_valid), 64'd0);
    drive(1, enc_r(7'd0, 5'd0, 5'd9, 3'd0, 5'd10, OP_OP), 1, 0, 0, 5'd0, 64'd0);
    tick();
    chk("flush_wb_a", a_rd1, 64'h55);
    chk("flush_wb_b", b_rd1, 64'h55);

    // Immediate and illegal-opcode corners.
    drive(1, enc_b(13'h1FFC, 5'd2, 5'd1, 3'd0), 1, 0, 0, 5'd0, 64'd0);
    tick();
    chk("beq_m4_a", a_imm, 64'hFFFF_FFFC);
    chk("beq_m4_b", b_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1, {20'h12345, 5'd5, OP_LUI}, 1, 0, 0, 5'd0, 64'd0);
    tick();
    chk("lui_a", a_imm, 64'h1234_5000);
    chk("lui_b", b_imm, 64'h1234_5000);
    drive(1, 32'h0000_007F, 1, 0, 0, 5'd0, 64'd0);
    tick();
    chk("illegal_a", 64'(a_ill), 64'd1);
    chk("illegal_valid", 64'(a_valid), 64'd1);

    // Reset asserted mid-hold clears the stage and the register file.
    drive(0, 32'd0, 1, 0, 1, 5'd5, 64'hABC);
    tick();
    drive(1, enc_r(7'd0, 5'd0, 5'd5, 3'd0, 5'd6, OP_OP), 1, 0, 0, 5'd0, 64'd0);
    tick();
    drive(0, 32'd0, 0, 0, 0, 5'd0, 64'd0);
    tick();
    chk("pre_rst_hold", 64'(a_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_a_valid", 64'(a_valid), 64'd0);
    chk("midrst_b_valid", 64'(b_valid), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, enc_r(7'd0, 5'd0, 5'd5, 3'd0, 5'd6, OP_OP), 1, 0, 0, 5'd0, 64'd0);
    tick();
    chk("x5_after_rst_a", a_rd1, 64'd0);
    chk("x5_after_rst_b", b_rd1, 64'd0);

    // Randomized traffic against the model.
    repeat (800) begin
      drive(($urandom_range(0, 3) != 0), rand_inst(), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)), {$urandom, $urandom});
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
